// File: rtl/fetch_pc_sequencer.sv
// Next-fetch-PC generator: priority redirect mux plus sequential PC, with a redirect
// latch that survives backend freezes and an epoch that counts applied corrections.
module fetch_pc_sequencer #(
  parameter int unsigned       PC_W     = 32,
  parameter int unsigned       NSRC     = 4,
  parameter int unsigned       INCR     = 1,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter int unsigned       EPOCH_W  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   freeze,
  input  logic [NSRC-1:0]        src_valid,
  input  logic [NSRC*PC_W-1:0]   src_pc,
  input  logic [NSRC-1:0]        src_is_pred,
  output logic [PC_W-1:0]        pc,
  output logic                   redirect,
  output logic [EPOCH_W-1:0]     epoch,
  output logic                   pending
);

  localparam int unsigned      IDX_W   = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam logic [PC_W-1:0]  INCR_PC = PC_W'(INCR);

  typedef enum logic {
    RUN  = 1'b0,
    HELD = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               redirect_q, redirect_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [IDX_W-1:0]   lat_idx_q, lat_idx_d;
  logic [PC_W-1:0]    lat_pc_q, lat_pc_d;
  logic               lat_pred_q, lat_pred_d;

  logic               win_vld;
  logic [IDX_W-1:0]   win_idx;
  logic [PC_W-1:0]    win_pc;
  logic               win_pred;

  logic               take_new;
  logic               apply;
  logic [PC_W-1:0]    app_pc;
  logic               app_pred;

  // Scan from lowest priority upward so the lowest valid index is the last write.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    win_pc   = '0;
    win_pred = 1'b0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (src_valid[i]) begin
        win_vld  = 1'b1;
        win_idx  = IDX_W'(i);
        win_pc   = src_pc[i*PC_W +: PC_W];
        win_pred = src_is_pred[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = redirect_q;
    epoch_d    = epoch_q;
    lat_idx_d  = lat_idx_q;
    lat_pc_d   = lat_pc_q;
    lat_pred_d = lat_pred_q;
    apply      = 1'b0;
    app_pc     = win_pc;
    app_pred   = win_pred;

    // Equal index also wins so a re-asserting source refreshes its own latched target.
    take_new = win_vld && ((state_q == RUN) || (win_idx <= lat_idx_q));

    if (freeze && take_new) begin
      lat_idx_d  = win_idx;
      lat_pc_d   = win_pc;
      lat_pred_d = win_pred;
    end

    unique case (state_q)
      RUN: begin
        if (!freeze) begin
          if (win_vld) begin
            apply = 1'b1;
          end else begin
            pc_d       = pc_q + INCR_PC;
            redirect_d = 1'b0;
          end
        end else if (win_vld) begin
          state_d = HELD;
        end
      end
      HELD: begin
        if (!freeze) begin
          apply   = 1'b1;
          state_d = RUN;
          if (!take_new) begin
            app_pc   = lat_pc_q;
            app_pred = lat_pred_q;
          end
        end
      end
    endcase

    if (apply) begin
      pc_d       = app_pc;
      redirect_d = app_pred;
      if (!app_pred) begin
        epoch_d = epoch_q + EPOCH_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      epoch_q    <= '0;
      lat_idx_q  <= '0;
      lat_pc_q   <= '0;
      lat_pred_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      epoch_q    <= epoch_d;
      lat_idx_q  <= lat_idx_d;
      lat_pc_q   <= lat_pc_d;
      lat_pred_q <= lat_pred_d;
    end
  end

  assign pc       = pc_q;
  assign redirect = redirect_q;
  assign epoch    = epoch_q;
  assign pending  = (state_q == HELD);

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Scoreboarded bench for fetch_pc_sequencer: each step queues the expected post-edge outputs.
module tb_fetch_pc_sequencer;

  localparam int PC_W    = 32;
  localparam int NSRC    = 4;
  localparam int EPOCH_W = 3;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  freeze = 1'b0;
  logic [NSRC-1:0]       src_valid = '0;
  logic [NSRC*PC_W-1:0]  src_pc = '0;
  logic [NSRC-1:0]       src_is_pred = '0;
  logic [PC_W-1:0]       pc;
  logic                  redirect;
  logic [EPOCH_W-1:0]    epoch;
  logic                  pending;

  typedef struct {
    logic [PC_W-1:0]    pc;
    logic               red;
    logic [EPOCH_W-1:0] ep;
    logic               pend;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  fetch_pc_sequencer #(
    .PC_W    (PC_W),
    .NSRC    (NSRC),
    .INCR    (1),
    .RESET_PC(32'h100),
    .EPOCH_W (EPOCH_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .freeze     (freeze),
    .src_valid  (src_valid),
    .src_pc     (src_pc),
    .src_is_pred(src_is_pred),
    .pc         (pc),
    .redirect   (redirect),
    .epoch      (epoch),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs after the edge, then check them.
  task automatic step(input string tag, input logic rst, input logic frz,
                      input logic [3:0] v, input logic [3:0] p,
                      input logic [31:0] t0, input logic [31:0] t1,
                      input logic [31:0] t2, input logic [31:0] t3,
                      input logic [31:0] e_pc, input logic e_red,
                      input logic [2:0] e_ep, input logic e_pend);
    exp_t e;
    @(negedge clk);
    reset       = rst;
    freeze      = frz;
    src_valid   = v;
    src_is_pred = p;
    src_pc      = {t3, t2, t1, t0};
    e.pc = e_pc; e.red = e_red; e.ep = e_ep; e.pend = e_pend;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({tag, ".pc"},       64'(pc),       64'(e.pc));
      check({tag, ".redirect"}, 64'(redirect), 64'(e.red));
      check({tag, ".epoch"},    64'(epoch),    64'(e.ep));
      check({tag, ".pending"},  64'(pending),  64'(e.pend));
    end
  endtask

  initial begin
    //     tag        rst frz v        p        t0           t1      t2      t3      pc           red ep pend
    step("reset",     1, 0, 4'b0000, 4'b0000, 0,           0,      0,      0,      32'h100,     0, 0, 0);
    step("seq1",      0, 0, 4'b0000, 4'b0000, 0,           0,      0,      0,      32'h101,     0, 0, 0);
    step("seq2",      0, 0, 4'b0000, 4'b0000, 0,           0,      0,      0,      32'h102,     0, 0, 0);
    step("seq3",      0, 0, 4'b0000, 4'b0000, 0,           0,      0,      0,      32'h103,     0, 0, 0);
    step("prio",      0, 0, 4'b1010, 4'b0000, 0,           32'h40, 0,      32'h80, 32'h40,      0, 1, 0);
    step("pred",      0, 0, 4'b1000, 4'b1000, 0,           0,      0,      32'h200,32'h200,     1, 1, 0);
    step("frz_idle",  0, 1, 4'b0000, 4'b0000, 0,           0,      0,      0,      32'h200,     1, 1, 0);
    step("post_pred", 0, 0, 4'b0000, 4'b0000, 0,           0,      0,      0,      32'h201,     0, 1, 0);
    step("hold_c1",   0, 1, 4'b0100, 4'b0000, 0,           0,      32'h300,0,      32'h201,     0, 1, 1);
    step("hold_c2",   0, 1, 4'b1000, 4'b0000, 0,           0,      0,      32'h400,32'h201,     0, 1, 1);
    step("hold_c3",   0, 1, 4'b0001, 4'b0000, 32'h500,     0,      0,      0,      32'h201,     0, 1, 1);
    step("release",   0, 0, 4'b0000, 4'b0000, 0,           0,      0,      0,      32'h500,     0, 2, 0);
    step("post_rel",  0, 0, 4'b0000, 4'b0000, 0,           0,      0,      0,      32'h501,     0, 2, 0);
    // A live winner at release beats the latched entry when its priority is at least as high.
    step("lat_pred2", 0, 1, 4'b0100, 4'b0100, 0,           0,      32'h700,0,      32'h501,     0, 2, 1);
    step("rel_live",  0, 0, 4'b0010, 4'b0000, 0,           32'h710,0,      0,      32'h710,     0, 3, 0);
    step("lat_s1",    0, 1, 4'b0010, 4'b0000, 0,           32'h720,0,      0,      32'h710,     0, 3, 1);
    step("rel_lat",   0, 0, 4'b1000, 4'b1000, 0,           0,      0,      32'h730,32'h720,     0, 4, 0);
    step("lat_pr",    0, 1, 4'b0100, 4'b0100, 0,           0,      32'h740,0,      32'h720,     0, 4, 1);
    step("rel_pr",    0, 0, 4'b0000, 4'b0000, 0,           0,      0,      0,      32'h740,     1, 4, 0);
    step("same_a",    0, 1, 4'b0010, 4'b0000, 0,           32'h750,0,      0,      32'h740,     1, 4, 1);
    step("same_b",    0, 1, 4'b0010, 4'b0000, 0,           32'h760,0,      0,      32'h740,     1, 4, 1);
    step("rel_same",  0, 0, 4'b0000, 4'b0000, 0,           0,      0,      0,      32'h760,     0, 5, 0);
    // Reset while HELD must drop the latched 0x600.
    step("lat_600",   0, 1, 4'b0010, 4'b0000, 0,           32'h600,0,      0,      32'h760,     0, 5, 1);
    step("rst_held",  1, 1, 4'b0000, 4'b0000, 0,           0,      0,      0,      32'h100,     0, 0, 0);
    step("after_r1",  0, 0, 4'b0000, 4'b0000, 0,           0,      0,      0,      32'h101,     0, 0, 0);
    step("after_r2",  0, 0, 4'b0000, 4'b0000, 0,           0,      0,      0,      32'h102,     0, 0, 0);
    step("to_ones",   0, 0, 4'b0001, 4'b0000, 32'hFFFFFFFF,0,      0,      0,      32'hFFFFFFFF,0, 1, 0);
    step("pc_wrap",   0, 0, 4'b0000, 4'b0000, 0,           0,      0,      0,      32'h0,       0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      step($sformatf("ep_wrap%0d", i), 0, 0, 4'b0001, 4'b0000, 32'h1000 + 32'(i), 0, 0, 0,
           32'h1000 + 32'(i), 0, 3'((2 + i) % 8), 0);
    end
    step("ep_final",  0, 0, 4'b0000, 4'b0000, 0,           0,      0,      0,      32'h1008,    0, 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
